// File: rtl/bcd_multidigit_seq_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | bcd_pkg: shared BCD constants, FSM state type and digit helpers.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package bcd_pkg;

  localparam int         DIG_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [4:0] BCD_ADJ = 5'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Truncating subtract: invalid digits wrap rather than saturate.
  function automatic logic [DIG_W-1:0] nines_comp(input logic [DIG_W-1:0] digit);
    return BCD_MAX - digit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_multidigit_seq_ctrl_if.sv
// +----------------------------------------------------------------------+
// | bcd_multidigit_seq_ctrl_if: operand/result bus of the BCD sequencer. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface bcd_multidigit_seq_ctrl_if #(
  parameter int NDIG = 4
);

  logic              start;
  logic              op_sub;
  logic              cin;
  logic [4*NDIG-1:0] a_in;
  logic [4*NDIG-1:0] b_in;
  logic              busy;
  logic              done;
  logic [4*NDIG-1:0] sum_out;
  logic              cout;
  logic              err;

  modport master (
    output start, op_sub, cin, a_in, b_in,
    input  busy, done, sum_out, cout, err
  );

  modport slave (
    input  start, op_sub, cin, a_in, b_in,
    output busy, done, sum_out, cout, err
  );

endinterface

`default_nettype wire

// File: rtl/bcd_multidigit_seq_ctrl_digit_add.sv
// +----------------------------------------------------------------------+
// | bcd_digit_add: combinational single-digit BCD adder with carry.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIG_W-1:0] a,
  input  logic [DIG_W-1:0] b,
  input  logic             c_in,
  output logic [DIG_W-1:0] s,
  output logic             c_out
);

  logic [4:0] w_z;
  logic [4:0] w_adj;

  assign w_z   = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
  assign w_adj = (w_z > {1'b0, BCD_MAX}) ? (w_z + BCD_ADJ) : w_z;
  assign {c_out, s} = w_adj;

endmodule

`default_nettype wire

// File: rtl/bcd_multidigit_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | bcd_multidigit_seq_ctrl: digit-serial NDIG-digit BCD add/subtract.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_multidigit_seq_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  bcd_multidigit_seq_ctrl_if.slave  bus
);

  localparam int            SW     = DIG_W * NDIG;
  localparam int            CW     = $clog2(NDIG + 1);
  localparam logic [CW-1:0] C_LAST = CW'(NDIG - 1);

  state_t          r_state;
  logic [SW-1:0]   r_a;
  logic [SW-1:0]   r_b;
  logic [SW-1:0]   r_sum;
  logic [CW-1:0]   r_cnt;
  logic            r_carry;
  logic            r_busy;
  logic            r_done;
  logic            r_cout;
  logic            r_err;

  logic [SW-1:0]    w_b_lat;
  logic [SW-1:0]    w_sum_next;
  logic             w_err;
  logic [DIG_W-1:0] w_s;
  logic             w_c;

  generate
    for (genvar i = 0; i < NDIG; i++) begin : g_bsel
      assign w_b_lat[i*DIG_W +: DIG_W] = bus.op_sub ? nines_comp(bus.b_in[i*DIG_W +: DIG_W])
                                                    : bus.b_in[i*DIG_W +: DIG_W];
    end
  endgenerate

  always_comb begin
    w_err = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if ((bus.a_in[i*DIG_W +: DIG_W] > BCD_MAX) || (bus.b_in[i*DIG_W +: DIG_W] > BCD_MAX))
        w_err = 1'b1;
    end
  end

  bcd_digit_add u_digit_add (
    .a     (r_a[DIG_W-1:0]),
    .b     (r_b[DIG_W-1:0]),
    .c_in  (r_carry),
    .s     (w_s),
    .c_out (w_c)
  );

  // New digit enters at the MSD end so digit 0 lands in [3:0] after NDIG shifts.
  assign w_sum_next = (r_sum >> DIG_W) | (SW'(w_s) << (DIG_W * (NDIG - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_a     <= bus.a_in;
            r_b     <= w_b_lat;
            r_carry <= bus.op_sub ? 1'b1 : bus.cin;
            r_err   <= w_err;
            r_cnt   <= '0;
            r_sum   <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_c;
          r_a     <= r_a >> DIG_W;
          r_b     <= r_b >> DIG_W;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_cout  <= w_c;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.sum_out = r_sum;
  assign bus.cout    = r_cout;
  assign bus.err     = r_err;

endmodule

`default_nettype wire
